// File: rtl/notnot_pkg.sv
// Shared definitions for the NOT-NOT round scheduler.
// Key codes, FSM encoding and prompt helpers.
package notnot_pkg;

  localparam int NUM_CODES = 6;

  typedef enum logic [2:0] {
    KEY_UP    = 3'd0,
    KEY_DOWN  = 3'd1,
    KEY_LEFT  = 3'd2,
    KEY_RIGHT = 3'd3,
    KEY_VOWEL = 3'd4,
    KEY_DIGIT = 3'd5
  } key_code_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_KEY  = 3'd2,
    S_CORRECT   = 3'd3,
    S_WRONG     = 3'd4,
    S_GAME_OVER = 3'd5
  } state_e;

  // Folds a raw 3-bit random value into the 0..5 code range.
  function automatic logic [2:0] fold_code(
    input logic [2:0] raw
  );
    return (raw < 3'(NUM_CODES)) ? raw : raw - 3'(NUM_CODES);
  endfunction

  function automatic logic judge(
    input logic [2:0] prompt,
    input logic       negated,
    input logic [2:0] code
  );
    return negated ? (code != prompt) : (code == prompt);
  endfunction

endpackage

// File: rtl/prompt_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Nonzero seed keeps it off the all-zero lockup state.
module prompt_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] state
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  assign fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d = {lfsr_q[14:0], fb};
  assign state  = lfsr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/round_scheduler.sv
// NOT-NOT round scheduler: issues prompts, judges keys,
// tracks lives and score. All outputs are registered.
module round_scheduler
  import notnot_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 150000000,
  parameter int          RESULT_CYCLES  = 50000000,
  parameter int          LIVES          = 3,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       key_valid,
  input  logic [2:0] key_code,
  output logic [2:0] prompt,
  output logic       prompt_not,
  output logic       prompt_valid,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       result_correct,
  output logic       result_wrong,
  output logic       game_over
);

  localparam int MAXC = (TIMEOUT_CYCLES > RESULT_CYCLES) ?
                        TIMEOUT_CYCLES : RESULT_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] RES_LAST = TW'(RESULT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    prompt_q, prompt_d;
  logic          not_q, not_d;
  logic [1:0]    lives_q, lives_d;
  logic [7:0]    score_q, score_d;
  logic          pv_q, rc_q, rw_q, go_q;

  logic [15:0] lfsr;
  logic        lfsr_unused;
  logic        key_ok;

  prompt_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .state  (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:4];
  assign key_ok      = key_valid && (key_code < 3'(NUM_CODES));

  always_comb begin
    state_d  = state_q;
    prompt_d = prompt_q;
    not_d    = not_q;
    lives_d  = lives_q;
    score_d  = score_q;
    timer_d  = timer_q + 1'b1;
    unique case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start) begin
          lives_d = 2'(LIVES);
          score_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        prompt_d = fold_code(lfsr[2:0]);
        not_d    = lfsr[3];
        state_d  = S_WAIT_KEY;
      end
      S_WAIT_KEY: begin
        // A legal key beats a same-cycle timeout.
        if (key_ok && judge(prompt_q, not_q, key_code)) begin
          state_d = S_CORRECT;
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
        end else if (key_ok || timer_q == TO_LAST) begin
          state_d = S_WRONG;
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
        end
      end
      S_CORRECT: begin
        if (timer_q == RES_LAST) state_d = S_ISSUE;
      end
      S_WRONG: begin
        if (timer_q == RES_LAST) begin
          state_d = (lives_q == 2'd0) ? S_GAME_OVER : S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      prompt_q <= '0;
      not_q    <= 1'b0;
      lives_q  <= '0;
      score_q  <= '0;
      pv_q     <= 1'b0;
      rc_q     <= 1'b0;
      rw_q     <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      prompt_q <= prompt_d;
      not_q    <= not_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      pv_q     <= (state_d == S_WAIT_KEY);
      rc_q     <= (state_d == S_CORRECT);
      rw_q     <= (state_d == S_WRONG);
      go_q     <= (state_d == S_GAME_OVER);
    end
  end

  assign prompt         = prompt_q;
  assign prompt_not     = not_q;
  assign prompt_valid   = pv_q;
  assign lives          = lives_q;
  assign score          = score_q;
  assign result_correct = rc_q;
  assign result_wrong   = rw_q;
  assign game_over      = go_q;

endmodule

// File: tb/tb_round_scheduler.sv
// Randomized bench for round_scheduler against a
// round-level game model (TIMEOUT=8, RESULT=2).
module tb_round_scheduler;

  localparam int          TO   = 8;
  localparam int          RC   = 2;
  localparam int          NL   = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       key_valid = 1'b0;
  logic [2:0] key_code = 3'd0;
  logic [2:0] prompt;
  logic       prompt_not;
  logic       prompt_valid;
  logic [1:0] lives;
  logic [7:0] score;
  logic       result_correct;
  logic       result_wrong;
  logic       game_over;

  round_scheduler #(
    .TIMEOUT_CYCLES(TO),
    .RESULT_CYCLES (RC),
    .LIVES         (NL),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .prompt        (prompt),
    .prompt_not    (prompt_not),
    .prompt_valid  (prompt_valid),
    .lives         (lives),
    .score         (score),
    .result_correct(result_correct),
    .result_wrong  (result_wrong),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference random source: the LFSR sequence from the seed.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= SEED;
    else m_lfsr <= {m_lfsr[14:0],
                    m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  int         exp_lives;
  int         exp_score;
  logic [2:0] exp_p;
  logic       exp_n;
  int         n_ok;
  int         n_wrong;
  int         n_to;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called while the DUT sits in its one-cycle issue step.
  task automatic issue_prompt();
    logic [2:0] r;
    r     = m_lfsr[2:0];
    exp_p = (r < 3'd6) ? r : r - 3'd6;
    exp_n = m_lfsr[3];
    check("issue_pv", prompt_valid, 0);
    tick();
    check("pv", prompt_valid, 1);
    check("prompt", prompt, exp_p);
    check("prompt_not", prompt_not, exp_n);
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_lives = NL;
    exp_score = 0;
    check("start_lives", lives, exp_lives);
    check("start_score", score, 0);
    check("start_go", game_over, 0);
    issue_prompt();
  endtask

  task automatic play_round();
    bit         tmo;
    int         d;
    int         last;
    logic [2:0] code;
    bit         ok;
    tmo  = ($urandom_range(0, 3) == 0);
    d    = $urandom_range(0, TO - 1);
    last = tmo ? TO : d;
    if ($urandom_range(0, 1) == 1)
      code = exp_n ? 3'((exp_p + 1) % 6) : exp_p;
    else
      code = 3'($urandom_range(0, 5));
    for (int i = 0; i < last; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        key_valid = 1'b1;
        key_code  = 3'd6 + 3'($urandom_range(0, 1));
      end
      tick();
      key_valid = 1'b0;
      if (!(tmo && i == last - 1)) begin
        check("wait_pv", prompt_valid, 1);
        check("wait_rw", result_wrong, 0);
      end
    end
    if (tmo) begin
      ok = 1'b0;
      n_to++;
    end else begin
      key_valid = 1'b1;
      key_code  = code;
      tick();
      key_valid = 1'b0;
      ok = exp_n ? (code != exp_p) : (code == exp_p);
    end
    if (ok) begin
      n_ok++;
      if (exp_score < 255) exp_score++;
    end else begin
      n_wrong++;
      if (exp_lives > 0) exp_lives--;
    end
    check("res_ok", result_correct, ok);
    check("res_wrong", result_wrong, !ok);
    check("res_score", score, exp_score);
    check("res_lives", lives, exp_lives);
    check("res_pv", prompt_valid, 0);
    key_valid = 1'b1;
    key_code  = exp_n ? 3'((exp_p + 1) % 6) : exp_p;
    start     = 1'b1;
    tick();
    key_valid = 1'b0;
    check("hold_ok", result_correct, ok);
    check("hold_wrong", result_wrong, !ok);
    check("hold_score", score, exp_score);
    check("hold_lives", lives, exp_lives);
    tick();
    start = 1'b0;
    check("post_ok", result_correct, 0);
    check("post_wrong", result_wrong, 0);
    if (exp_lives == 0) begin
      check("go", game_over, 1);
      check("go_lives", lives, 0);
    end else begin
      check("no_go", game_over, 0);
      issue_prompt();
    end
  endtask

  initial begin
    n_ok = 0;
    n_wrong = 0;
    n_to = 0;
    #22;
    reset_n = 1'b1;
    check("rst_lives", lives, 0);
    check("rst_score", score, 0);
    check("rst_prompt", prompt, 0);
    check("rst_pv", prompt_valid, 0);
    check("rst_go", game_over, 0);
    key_valid = 1'b1;
    key_code  = 3'd0;
    tick();
    tick();
    key_valid = 1'b0;
    check("idle_pv", prompt_valid, 0);
    check("idle_rc", result_correct, 0);

    for (int g = 0; g < 4; g++) begin
      int n;
      start_game();
      n = 0;
      while (exp_lives > 0 && n < 80) begin
        play_round();
        n++;
      end
      check("game_ended", exp_lives, 0);
      tick();
      tick();
      check("go_hold", game_over, 1);
      check("go_hold_lives", lives, 0);
      check("go_hold_score", score, exp_score);
    end

    start_game();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_pv", prompt_valid, 0);
    check("mid_rst_lives", lives, 0);
    check("mid_rst_score", score, 0);
    check("mid_rst_prompt", prompt, 0);
    check("mid_rst_not", prompt_not, 0);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 3'd1;
    reset_n   = 1'b1;
    tick();
    tick();
    key_valid = 1'b0;
    check("rel_pv", prompt_valid, 0);
    check("rel_lives", lives, 0);
    check("rel_score", score, 0);
    check("rel_rc", result_correct, 0);
    check("rel_rw", result_wrong, 0);
    start_game();
    play_round();
    play_round();

    check("saw_correct", n_ok > 0, 1);
    check("saw_timeout", n_to > 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_scheduler.md
ROUND_SCHEDULER -- requirements
Module: round_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 150000000, answer window per prompt (3 s at 50 MHz).
REQ-002 SHALL have parameter RESULT_CYCLES, default 50000000, feedback hold time after each judgement.
REQ-003 SHALL have parameter LIVES, default 3, lives granted at game start (1..3).
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  in  1  begin game, sampled in IDLE/GAME_OVER.
REQ-008 SHALL have port key_valid  in  1  single-cycle keyboard press strobe.
REQ-009 SHALL have port key_code  in  3  0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 VOWEL, 5 DIGIT; 6-7 invalid.
REQ-010 SHALL have port prompt  out  3  current instruction code.
REQ-011 SHALL have port prompt_not  out  1  instruction negated ("NOT x").
REQ-012 SHALL have port prompt_valid  out  1  high in WAIT_KEY.
REQ-013 SHALL have port lives  out  2  remaining lives.
REQ-014 SHALL have port score  out  8  correct answers, saturating.
REQ-015 SHALL have ports result_correct, result_wrong  out  1 each  high in CORRECT / WRONG.
REQ-016 SHALL have port game_over  out  1  high in GAME_OVER.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT_KEY, CORRECT, WRONG, GAME_OVER; all outputs registered.
REQ-018 SHALL free-run a 16-bit Fibonacci LFSR (taps 16,14,13,11) every cycle; all-zero never reachable.
REQ-019 IDLE: start=1 -> lives<=LIVES, score<=0, next ISSUE.
REQ-020 ISSUE (1 cycle): prompt<=lfsr[2:0] if <6 else lfsr[2:0]-6; prompt_not<=lfsr[3]; timer<=0; next WAIT_KEY.
REQ-021 WAIT_KEY: timer increments each cycle; key_valid with key_code 6/7 SHALL be ignored.
REQ-022 Valid key SHALL be correct iff (prompt_not=0 and key_code==prompt) or (prompt_not=1 and key_code!=prompt).
REQ-023 Judgement latency: key in cycle n -> CORRECT/WRONG, score/lives updated and result flag high in cycle n+1.
REQ-024 No valid key by timer==TIMEOUT_CYCLES-1 -> WRONG (timeout always wrong, including negated prompts).
REQ-025 Valid key in the same cycle as timeout SHALL win; key judged normally.
REQ-026 CORRECT: score+1 on entry, saturating at 255; hold RESULT_CYCLES cycles; next ISSUE.
REQ-027 WRONG: lives-1 on entry (never below 0); hold RESULT_CYCLES cycles; next GAME_OVER if lives==0 else ISSUE.
REQ-028 GAME_OVER: score and lives hold; start=1 -> reload lives/score as IDLE, next ISSUE.
REQ-029 key_valid outside WAIT_KEY SHALL be ignored; start outside IDLE/GAME_OVER SHALL be ignored.
REQ-030 Timer SHALL be one shared counter, cleared on every state entry, width ceil(log2(max(TIMEOUT_CYCLES,RESULT_CYCLES))).

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE, lfsr=LFSR_SEED, timer=0, prompt=0, prompt_not=0, lives=0, score=0, all flags 0.
REQ-032 Reset mid-round SHALL discard the round; no score or life update on release.

Structure
REQ-033 Key codes, state encoding and code count (6) SHALL live in shared package notnot_pkg.
REQ-034 LFSR SHALL be sub-module prompt_lfsr (clk, reset_n, seed param, 16-bit state out).
REQ-035 Timer and life/score counters SHALL be inline; no separate timer instance.

Verification (TIMEOUT_CYCLES=8, RESULT_CYCLES=2)
REQ-036 Reset, start pulse -> ISSUE next cycle, lives=3, score=0, prompt_valid high 2 cycles after start.
REQ-037 prompt=2, prompt_not=0, key_code=2 -> result_correct next cycle, score 0->1, lives unchanged.
REQ-038 prompt=2, prompt_not=1, key_code=2 -> result_wrong, lives 3->2; key_code=5 instead -> correct.
REQ-039 No key for 8 cycles in WAIT_KEY -> result_wrong, lives-1; key on cycle 8 -> judged, not timeout.
REQ-040 Three wrong rounds -> game_over after third WRONG hold, lives=0; start -> lives=3, score=0, ISSUE.
REQ-041 key_code=7 and keys during CORRECT/WRONG -> no state, score or lives change; reset_n low mid-WAIT_KEY -> IDLE immediately.
